instr_fetch: RTL and testbench



---
 rtl/cpu_pkg.sv | 19 +
 rtl/instr_fetch.sv | 141 ++++++++++++++
 tb/tb_instr_fetch.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM states and front-end defaults.
// The microcode decoder imports the same long-instruction marker bit.
package cpu_pkg;

    typedef enum logic [1:0] {
        FETCH_OP  = 2'd0,
        FETCH_ARG = 2'd1,
        HOLD      = 2'd2
    } fetch_state_t;

    localparam int DEFAULT_LONG_BIT     = 7;
    localparam int DEFAULT_RESET_VECTOR = 0;

    // True when the opcode byte announces a trailing operand byte.
    function automatic logic is_long(input logic [7:0] op, input int long_bit);
        return op[long_bit];
    endfunction

endpackage

// File: rtl/instr_fetch.sv
// CPU front end: walks the PC, fetches 1- or 2-byte instructions over req/ack
// and hands them to the decoder over valid/ready, with redirect and flush.
module instr_fetch
    import cpu_pkg::*;
#(
    parameter int                ADDR_W       = 8,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(DEFAULT_RESET_VECTOR),
    parameter int                LONG_BIT     = DEFAULT_LONG_BIT
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [7:0]        mem_rdata,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [7:0]        opcode,
    output logic [7:0]        operand,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc
);

    fetch_state_t      state_reg, state_next;
    logic [ADDR_W-1:0] pc_reg, pc_next;
    logic              flush_reg, flush_next;
    logic              mem_req_reg, mem_req_next;
    logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;
    logic              instr_valid_reg, instr_valid_next;
    logic [7:0]        opcode_reg, opcode_next;
    logic [7:0]        operand_reg, operand_next;
    logic [ADDR_W-1:0] instr_pc_reg, instr_pc_next;
    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] hold_target;

    assign pc_inc      = pc_reg + ADDR_W'(1);
    assign hold_target = redirect ? redirect_pc : pc_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= FETCH_OP;
            pc_reg          <= RESET_VECTOR;
            flush_reg       <= 1'b0;
            mem_req_reg     <= 1'b0;
            mem_addr_reg    <= RESET_VECTOR;
            instr_valid_reg <= 1'b0;
            opcode_reg      <= 8'h00;
            operand_reg     <= 8'h00;
            instr_pc_reg    <= RESET_VECTOR;
        end else begin
            state_reg       <= state_next;
            pc_reg          <= pc_next;
            flush_reg       <= flush_next;
            mem_req_reg     <= mem_req_next;
            mem_addr_reg    <= mem_addr_next;
            instr_valid_reg <= instr_valid_next;
            opcode_reg      <= opcode_next;
            operand_reg     <= operand_next;
            instr_pc_reg    <= instr_pc_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        pc_next          = pc_reg;
        flush_next       = flush_reg;
        mem_req_next     = mem_req_reg;
        mem_addr_next    = mem_addr_reg;
        instr_valid_next = instr_valid_reg;
        opcode_next      = opcode_reg;
        operand_next     = operand_reg;
        instr_pc_next    = instr_pc_reg;

        case (state_reg)
            FETCH_OP, FETCH_ARG: begin
                if (!mem_req_reg) begin
                    // Only reachable in the first cycle after reset: open the first request.
                    mem_req_next  = 1'b1;
                    pc_next       = hold_target;
                    mem_addr_next = hold_target;
                    state_next    = FETCH_OP;
                end else if (mem_ack) begin
                    if (redirect) begin
                        pc_next       = redirect_pc;
                        mem_addr_next = redirect_pc;
                        flush_next    = 1'b0;
                        state_next    = FETCH_OP;
                    end else if (flush_reg) begin
                        // Stale data from before the redirect; restart at the new PC.
                        flush_next    = 1'b0;
                        mem_addr_next = pc_reg;
                        state_next    = FETCH_OP;
                    end else if (state_reg == FETCH_OP) begin
                        opcode_next   = mem_rdata;
                        instr_pc_next = pc_reg;
                        pc_next       = pc_inc;
                        if (is_long(mem_rdata, LONG_BIT)) begin
                            mem_addr_next = pc_inc;
                            state_next    = FETCH_ARG;
                        end else begin
                            operand_next     = 8'h00;
                            mem_req_next     = 1'b0;
                            instr_valid_next = 1'b1;
                            state_next       = HOLD;
                        end
                    end else begin
                        operand_next     = mem_rdata;
                        pc_next          = pc_inc;
                        mem_req_next     = 1'b0;
                        instr_valid_next = 1'b1;
                        state_next       = HOLD;
                    end
                end else if (redirect) begin
                    // Request must stay up until acked; remember to drop its data.
                    pc_next    = redirect_pc;
                    flush_next = 1'b1;
                    state_next = FETCH_OP;
                end
            end
            HOLD: begin
                if (redirect || instr_ready) begin
                    instr_valid_next = 1'b0;
                    mem_req_next     = 1'b1;
                    pc_next          = hold_target;
                    mem_addr_next    = hold_target;
                    state_next       = FETCH_OP;
                end
            end
            default: state_next = FETCH_OP;
        endcase
    end

    assign mem_req     = mem_req_reg;
    assign mem_addr    = mem_addr_reg;
    assign instr_valid = instr_valid_reg;
    assign opcode      = opcode_reg;
    assign operand     = operand_reg;
    assign instr_pc    = instr_pc_reg;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed vectors, corner sequences and a
// randomized run against a program-level model of the instruction stream.
module tb_instr_fetch;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       mem_req;
    logic [7:0] mem_addr;
    logic       mem_ack;
    logic [7:0] mem_rdata;
    logic       instr_valid;
    logic       instr_ready;
    logic [7:0] opcode;
    logic [7:0] operand;
    logic [7:0] instr_pc;
    logic       redirect;
    logic [7:0] redirect_pc;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    instr_fetch #(.ADDR_W(8), .RESET_VECTOR(8'h00), .LONG_BIT(7)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .opcode      (opcode),
        .operand     (operand),
        .instr_pc    (instr_pc),
        .redirect    (redirect),
        .redirect_pc (redirect_pc)
    );

    // Program memory model: ack after a fixed or random number of wait states.
    logic [7:0] mem [256];
    int mem_wait   = 0;
    bit rand_waits = 1'b0;
    int wait_cnt;
    int cur_wait;
    int eff_wait;

    assign eff_wait  = rand_waits ? cur_wait : mem_wait;
    assign mem_ack   = rst_n & mem_req & (wait_cnt >= eff_wait);
    assign mem_rdata = mem[mem_addr];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= 0;
            cur_wait <= 0;
        end else begin
            wait_cnt <= (mem_req && !mem_ack) ? wait_cnt + 1 : 0;
            if (mem_req && mem_ack)
                cur_wait <= rand_waits ? int'($urandom_range(0, 2)) : 0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Protocol monitor, sampled well after the drivers settle.
    logic       p_rst = 1'b0, p_req = 1'b0, p_ack = 1'b0;
    logic       p_valid = 1'b0, p_ready = 1'b0, p_redir = 1'b0;
    logic [7:0] p_addr = 8'h00, p_op = 8'h00, p_opd = 8'h00, p_pc = 8'h00;

    always begin
        @(negedge clk);
        #3;
        if (rst_n) begin
            check("valid_excl_req", 32'(instr_valid & mem_req), 32'd0);
            if (p_rst && p_req && !p_ack)
                check("req_addr_held", {mem_req, mem_addr}, {1'b1, p_addr});
            if (p_rst && p_valid && !p_ready && !p_redir)
                check("instr_held", {instr_valid, opcode, operand, instr_pc},
                      {1'b1, p_op, p_opd, p_pc});
        end
        p_rst   <= rst_n;
        p_req   <= mem_req;
        p_ack   <= mem_ack;
        p_addr  <= mem_addr;
        p_valid <= instr_valid;
        p_ready <= instr_ready;
        p_redir <= redirect;
        p_op    <= opcode;
        p_opd   <= operand;
        p_pc    <= instr_pc;
    end

    task automatic do_reset();
        rst_n       = 1'b0;
        instr_ready = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 8'h00;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!instr_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("valid_seen", 32'(instr_valid), 32'd1);
    endtask

    task automatic accept();
        instr_ready = 1'b1;
        @(negedge clk);
        instr_ready = 1'b0;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    endtask

    typedef struct {
        logic [7:0] addr;
        logic [7:0] b0;
        logic [7:0] b1;
        int         waits;
        logic [7:0] exp_op;
        logic [7:0] exp_opd;
        logic [7:0] exp_pc;
        logic [7:0] exp_next;
        int         exp_cycles;
    } vec_t;

    vec_t tbl[5];

    initial begin
        int         n;
        int         accepted;
        logic [7:0] a1;
        logic [7:0] model_pc;
        logic [7:0] nxt;
        logic [7:0] e_op;
        logic [7:0] e_opd;

        tbl[0] = '{8'h10, 8'h12, 8'hEE, 0, 8'h12, 8'h00, 8'h10, 8'h11, 1};
        tbl[1] = '{8'h04, 8'h85, 8'h3C, 2, 8'h85, 8'h3C, 8'h04, 8'h06, 6};
        tbl[2] = '{8'hFF, 8'h80, 8'h5A, 1, 8'h80, 8'h5A, 8'hFF, 8'h01, 4};
        tbl[3] = '{8'h20, 8'h7F, 8'hC3, 3, 8'h7F, 8'h00, 8'h20, 8'h21, 4};
        tbl[4] = '{8'h30, 8'hFF, 8'h00, 0, 8'hFF, 8'h00, 8'h30, 8'h32, 2};

        // Reset values, first zero-wait fetch, then backpressure in HOLD.
        clear_mem();
        mem[0] = 8'h12;
        mem[1] = 8'h13;
        mem_wait = 0;
        do_reset();
        check("rst_outputs", {mem_req, mem_addr, instr_valid, opcode, operand, instr_pc}, 32'd0);
        @(negedge clk);
        check("first_req", {mem_req, mem_addr, instr_valid}, {1'b1, 8'h00, 1'b0});
        @(negedge clk);
        check("first_instr", {instr_valid, mem_req, opcode, operand, instr_pc},
              {1'b1, 1'b0, 8'h12, 8'h00, 8'h00});
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("backpressure", {instr_valid, mem_req, opcode, instr_pc},
                  {1'b1, 1'b0, 8'h12, 8'h00});
        end
        accept();
        check("after_accept", {instr_valid, mem_req, mem_addr}, {1'b0, 1'b1, 8'h01});
        wait_valid(n);
        check("second_instr", {opcode, operand, instr_pc}, {8'h13, 8'h00, 8'h01});
        $display("txn reset/backpressure: op=%02h pc=%02h", opcode, instr_pc);

        // Table: reach each address via a HOLD redirect, then time one fetch.
        for (int t = 0; t < 5; t++) begin
            clear_mem();
            mem[0] = 8'h5A;
            mem[tbl[t].addr] = tbl[t].b0;
            a1 = tbl[t].addr + 8'd1;
            mem[a1] = tbl[t].b1;
            mem_wait = 0;
            do_reset();
            wait_valid(n);
            redirect    = 1'b1;
            redirect_pc = tbl[t].addr;
            mem_wait    = tbl[t].waits;
            @(negedge clk);
            redirect = 1'b0;
            check("tbl_req_addr", {mem_req, instr_valid, mem_addr}, {1'b1, 1'b0, tbl[t].addr});
            wait_valid(n);
            check("tbl_opcode", opcode, tbl[t].exp_op);
            check("tbl_operand", operand, tbl[t].exp_opd);
            check("tbl_instr_pc", instr_pc, tbl[t].exp_pc);
            check("tbl_cycles", n, tbl[t].exp_cycles);
            accept();
            check("tbl_next_addr", {mem_req, mem_addr}, {1'b1, tbl[t].exp_next});
            $display("txn vec%0d: pc=%02h op=%02h arg=%02h cycles=%0d", t, instr_pc, opcode,
                     operand, n);
        end

        // Reset mid-fetch with a wait-stated request outstanding.
        mem_wait = 3;
        do_reset();
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check("midfetch_reset", {mem_req, instr_valid, mem_addr}, {1'b0, 1'b0, 8'h00});
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("restart_req", {mem_req, mem_addr}, {1'b1, 8'h00});
        $display("txn midfetch reset: restart addr=%02h", mem_addr);

        // Redirects during a wait-stated fetch at 7: last target wins, data dropped.
        clear_mem();
        mem[0]    = 8'h5A;
        mem[7]    = 8'h11;
        mem[8'h40] = 8'h22;
        mem[8'h60] = 8'h33;
        mem_wait = 0;
        do_reset();
        wait_valid(n);
        redirect    = 1'b1;
        redirect_pc = 8'h07;
        mem_wait    = 3;
        @(negedge clk);
        redirect_pc = 8'h60;
        @(negedge clk);
        redirect_pc = 8'h40;
        @(negedge clk);
        redirect = 1'b0;
        n = 0;
        while (mem_addr == 8'h07 && n < 20) begin
            check("flush_no_valid", 32'(instr_valid), 32'd0);
            @(negedge clk);
            n++;
        end
        check("flush_next_addr", {mem_req, instr_valid, mem_addr}, {1'b1, 1'b0, 8'h40});
        wait_valid(n);
        check("flush_instr", {opcode, instr_pc}, {8'h22, 8'h40});
        $display("txn flush redirect: op=%02h pc=%02h", opcode, instr_pc);

        // Redirect together with instr_ready in HOLD: consumed once, fetch at target.
        clear_mem();
        mem[0]     = 8'h5A;
        mem[1]     = 8'h01;
        mem[8'h20] = 8'h07;
        mem_wait = 0;
        do_reset();
        wait_valid(n);
        instr_ready = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 8'h20;
        @(negedge clk);
        instr_ready = 1'b0;
        redirect    = 1'b0;
        check("redir_ready", {instr_valid, mem_req, mem_addr}, {1'b0, 1'b1, 8'h20});
        wait_valid(n);
        check("redir_target_instr", {opcode, instr_pc}, {8'h07, 8'h20});
        $display("txn redirect+ready: op=%02h pc=%02h", opcode, instr_pc);

        // Randomized run against a program-order model of the instruction stream.
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        rand_waits = 1'b1;
        do_reset();
        @(negedge clk);
        model_pc = 8'h00;
        accepted = 0;
        for (int c = 0; c < 1500; c++) begin
            instr_ready = ($urandom_range(0, 2) != 0);
            redirect    = ($urandom_range(0, 19) == 0);
            redirect_pc = 8'($urandom);
            #1;
            if (instr_valid && instr_ready) begin
                e_op  = mem[model_pc];
                nxt   = model_pc + 8'd1;
                e_opd = e_op[7] ? mem[nxt] : 8'h00;
                check("rand_instr", {opcode, operand, instr_pc}, {e_op, e_opd, model_pc});
                $display("txn rand: pc=%02h op=%02h arg=%02h", instr_pc, opcode, operand);
                model_pc = model_pc + (e_op[7] ? 8'd2 : 8'd1);
                accepted++;
            end
            if (redirect) model_pc = redirect_pc;
            @(negedge clk);
        end
        instr_ready = 1'b0;
        redirect    = 1'b0;
        check("rand_progress", 32'(accepted > 100), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
